// File: rtl/gray_pkg.sv
`default_nettype none
// ==========================================================================
// gray_pkg : shared constants and helpers for the Gray codec pipeline
// Revision : 1.0
// ==========================================================================
package gray_pkg;

  localparam int   ERR_CNT_W = 16;
  localparam int   MAX_W     = 64;
  localparam logic MODE_B2G  = 1'b1;
  localparam logic MODE_G2B  = 1'b0;

  typedef logic [MAX_W-1:0]     word_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

  // Helpers work on a fixed wide word; callers zero-extend and slice.
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [6:0] popcount(input word_t v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

  function automatic int bits_per_stage(input int width, input int lat);
    return (width + lat - 1) / lat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gray_pipe_stage.sv
`default_nettype none
// ==========================================================================
// gray_pipe_stage : one register stage with its slice of the Gray decode chain
// Revision : 1.0
// ==========================================================================
module gray_pipe_stage
  import gray_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LAT   = 2,
  parameter int STAGE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic             up_mode_i,
  input  logic             up_err_i,
  output logic             dn_valid_o,
  input  logic             dn_ready_i,
  output logic [WIDTH-1:0] dn_data_o,
  output logic             dn_mode_o,
  output logic             dn_err_o
);

  localparam int BPS    = bits_per_stage(WIDTH, LAT);
  localparam int HI     = WIDTH - 1 - (STAGE - 1) * BPS;
  localparam int LO_RAW = WIDTH - STAGE * BPS;
  localparam int LO     = (STAGE == LAT || LO_RAW < 0) ? 0 : LO_RAW;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             mode_q;
  logic             err_q;
  logic [WIDTH-1:0] dec_w;

  // Bits above HI arrive already binary, so each resolved bit chains off its upper neighbour.
  always_comb begin
    dec_w = up_data_i;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i >= LO && i <= HI) begin
        dec_w[i] = dec_w[i+1] ^ up_data_i[i];
      end
    end
  end

  if (STAGE == 1) begin : g_first
    word_t enc_w;
    logic  unused_enc_par;
    assign enc_w          = bin2gray(word_t'(up_data_i));
    assign unused_enc_par = ^enc_w;
    assign data_d         = (up_mode_i == MODE_B2G) ? enc_w[WIDTH-1:0] : dec_w;
  end else begin : g_rest
    assign data_d = (up_mode_i == MODE_B2G) ? up_data_i : dec_w;
  end

  assign up_ready_o = !valid_q || dn_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else if (up_ready_o) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q <= data_d;
        mode_q <= up_mode_i;
        err_q  <= up_err_i;
      end
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_mode_o  = mode_q;
  assign dn_err_o   = err_q;

endmodule
`default_nettype wire

// File: rtl/gray_codec_pipe.sv
`default_nettype none
// ==========================================================================
// gray_codec_pipe : pipelined binary/Gray converter with Gray adjacency check
// Revision : 1.0
// ==========================================================================
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LAT        = 2,
  parameter bit ALLOW_HOLD = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_mode,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clear_count
);

  logic [LAT:0]     vld_w;
  logic [LAT:0]     rdy_w;
  logic [LAT:0]     mode_w;
  logic [LAT:0]     err_w;
  logic [WIDTH-1:0] data_w [0:LAT];

  logic             acc_w;
  logic             adj_err_w;
  logic [6:0]       pc_w;
  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] hist_d;
  logic             hist_vld_q;
  logic             hist_vld_d;
  err_cnt_t         cnt_q;
  err_cnt_t         cnt_d;

  assign vld_w[0]   = in_valid;
  assign data_w[0]  = in_data;
  assign mode_w[0]  = in_mode;
  assign err_w[0]   = adj_err_w;
  assign rdy_w[LAT] = out_ready;

  for (genvar s = 1; s <= LAT; s++) begin : g_stage
    gray_pipe_stage #(
      .WIDTH (WIDTH),
      .LAT   (LAT),
      .STAGE (s)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid_i (vld_w[s-1]),
      .up_ready_o (rdy_w[s-1]),
      .up_data_i  (data_w[s-1]),
      .up_mode_i  (mode_w[s-1]),
      .up_err_i   (err_w[s-1]),
      .dn_valid_o (vld_w[s]),
      .dn_ready_i (rdy_w[s]),
      .dn_data_o  (data_w[s]),
      .dn_mode_o  (mode_w[s]),
      .dn_err_o   (err_w[s])
    );
  end

  // Both handshakes are masked while rst is high so nothing transfers mid-reset.
  assign in_ready  = rdy_w[0] && !rst;
  assign out_valid = vld_w[LAT] && !rst;
  assign out_data  = data_w[LAT];
  assign out_mode  = mode_w[LAT];
  assign out_err   = err_w[LAT];

  assign acc_w = in_valid && in_ready;
  assign pc_w  = popcount(word_t'(in_data ^ hist_q));

  always_comb begin
    adj_err_w  = 1'b0;
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    if (in_mode == MODE_G2B && hist_vld_q) begin
      adj_err_w = (pc_w != 7'd1) && !(ALLOW_HOLD && pc_w == 7'd0);
    end
    if (acc_w) begin
      if (in_mode == MODE_B2G) begin
        hist_vld_d = 1'b0;
      end else begin
        hist_d     = in_data;
        hist_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_count) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && out_err && cnt_q != '1) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign err_count = cnt_q;

endmodule
`default_nettype wire
